// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   OP_J / OP_JAL : primary opcodes of the direct jumps (instr[31:26])
//   PC_STEP       : sequential fetch increment
//   fetch_entry_t : one fetch-queue slot {instr, pc, pred}
package mips_pkg;

  localparam logic [5:0]  OP_J    = 6'h02;
  localparam logic [5:0]  OP_JAL  = 6'h03;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched instructions for decode.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push_i     : write entry_i at the tail (ignored when full)
//   entry_i    : entry to write
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : empty the FIFO; overrides push and pop
//   head_o     : head entry (all-zero after reset)
//   count_o    : number of valid entries, 0..DEPTH
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  fetch_entry_t    entry_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign push_ok = push_i && (count_q != FullCnt);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch stage: owns the PC, issues one word fetch at a time over a
// req/gnt/rvalid handshake and buffers responses with their PCs for decode.
// Optional feature macro: FETCH_JUMP_PREDECODE_EN (redirect fetch locally on J/JAL).
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_req/addr     : fetch request and word address
//   imem_gnt          : memory accepts the request this cycle
//   imem_rvalid/rdata : fetch response
//   redirect_valid/pc : downstream redirect; flushes queue and in-flight fetch
//   out_valid/ready   : head handshake towards decode
//   out_instr/pc/pred : head instruction, its PC and predecoded-jump flag
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_pred
);

  localparam int unsigned    CntW    = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;

  logic [CntW-1:0] fifo_count;
  fetch_entry_t    head, enq_entry;
  logic            req_fire, rsp, enq, pop, enq_pred;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Only one fetch in flight and it holds a reserved slot, so a granted response always fits.
  assign imem_req  = rst_n && !outstanding_q && (fifo_count < FullCnt) && !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign req_fire  = imem_req && imem_gnt;
  assign rsp       = imem_rvalid && outstanding_q;
  assign enq       = rsp && !drop_q && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic [5:0]  rsp_op;
  logic [31:0] req_pc_plus4, jump_target;

  assign rsp_op       = imem_rdata[31:26];
  assign enq_pred     = (rsp_op == OP_J) || (rsp_op == OP_JAL);
  assign req_pc_plus4 = req_pc_q + PC_STEP;
  assign jump_target  = {req_pc_plus4[31:28], imem_rdata[25:0], 2'b00};
`else
  assign enq_pred = 1'b0;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (req_fire) begin
      outstanding_d = 1'b1;
      req_pc_d      = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_STEP;
    end

    if (rsp) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end

`ifdef FETCH_JUMP_PREDECODE_EN
    // No fetch can fire while a response is pending, so this only replaces the earlier +4.
    if (enq && enq_pred) fetch_pc_d = jump_target;
`endif

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // A response still in flight belongs to the old path; swallow it when it arrives.
      if (outstanding_q && !imem_rvalid) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_comb begin
    enq_entry       = '0;
    enq_entry.instr = imem_rdata;
    enq_entry.pc    = req_pc_q;
    enq_entry.pred  = enq_pred;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (enq),
    .entry_i(enq_entry),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .head_o (head),
    .count_o(fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_pred  = head.pred;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, back-pressure, redirects,
// jump predecode (both macro settings) and reset mid-operation.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, out_pred;
  logic [31:0] out_instr, out_pc;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model: auto mode answers every granted fetch one cycle later unless held.
  logic        gnt, mem_auto, mem_hold, man_rvalid, pend;
  logic [31:0] man_rdata, pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_1000) return 32'h0800_0040;
    return 32'h2008_0001 + {2'b00, addr[31:2]};
  endfunction

  assign imem_gnt    = gnt;
  assign imem_rvalid = mem_auto ? (pend && !mem_hold) : man_rvalid;
  assign imem_rdata  = mem_auto ? mem_word(pend_addr) : man_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (imem_req && imem_gnt) begin
      pend      <= 1'b1;
      pend_addr <= imem_addr;
    end else if (imem_rvalid && mem_auto) begin
      pend <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pred      (out_pred)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Holds reset for two cycles then releases it just after a falling edge.
  task automatic do_reset(input logic ready);
    rst_n          = 1'b0;
    mem_auto       = 1'b1;
    mem_hold       = 1'b0;
    man_rvalid     = 1'b0;
    man_rdata      = '0;
    gnt            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = ready;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    mem_auto       = 1'b1;
    mem_hold       = 1'b0;
    man_rvalid     = 1'b0;
    man_rdata      = '0;
    gnt            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    next_cycle();
    next_cycle();
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
    else n_pass++;
    n_checks++;
    if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if ({out_instr, out_pc, out_pred} !== 65'd0)
      $display("FAIL reset_outs: got %h %h %b want zeros", out_instr, out_pc, out_pred);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL first_req: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL stream_gap%0d: got %b want 0", i, out_valid);
      else n_pass++;
      next_cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'h2008_0001 + 32'(i))
        $display("FAIL stream_out%0d: got v=%b pc=%h ins=%h want 1 %h %h", i, out_valid, out_pc,
                 out_instr, 32'(4 * i), 32'h2008_0001 + 32'(i));
      else n_pass++;
    end
  endtask

  task automatic test_full();
    int fires = 0;
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      if (imem_req && imem_gnt) fires++;
      next_cycle();
    end
    n_checks++;
    if (fires !== 4) $display("FAIL full_fires: got %0d want 4", fires);
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL full_req: got %b want 0", imem_req);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0)
      $display("FAIL full_head: got v=%b pc=%h want 1 00000000", out_valid, out_pc);
    else n_pass++;
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL full_resume: got req=%b addr=%h want 1 00000010", imem_req, imem_addr);
    else n_pass++;
    n_checks++;
    if (out_pc !== 32'h4) $display("FAIL full_next_head: got %h want 00000004", out_pc);
    else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    mem_hold = 1'b1;
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL redir_req_mask: got %b want 0", imem_req);
    else n_pass++;
    next_cycle();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL redir_pending: got v=%b req=%b want 0 0", out_valid, imem_req);
    else n_pass++;
    next_cycle();
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL redir_new_req: got v=%b req=%b addr=%h want 0 1 00000100", out_valid,
               imem_req, imem_addr);
    else n_pass++;
    next_cycle();
    next_cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h2008_0041)
      $display("FAIL redir_first: got v=%b pc=%h ins=%h want 1 00000100 20080041", out_valid,
               out_pc, out_instr);
    else n_pass++;
    // Redirect coinciding with a response and a pop.
    out_ready = 1'b0;
    next_cycle();
    n_checks++;
    if (imem_rvalid !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL redir_setup: got rv=%b v=%b want 1 1", imem_rvalid, out_valid);
    else n_pass++;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL redir_rvalid: got v=%b req=%b addr=%h want 0 1 00000100", out_valid,
               imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_predecode_and_reset();
    logic        exp_pred;
    logic [31:0] exp_addr;
`ifdef FETCH_JUMP_PREDECODE_EN
    exp_pred = 1'b1;
    exp_addr = 32'h0000_0100;
`else
    exp_pred = 1'b0;
    exp_addr = 32'h0000_1004;
`endif
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1000;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1000)
      $display("FAIL pd_req: got req=%b addr=%h want 1 00001000", imem_req, imem_addr);
    else n_pass++;
    next_cycle();
    next_cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h1000 || out_instr !== 32'h0800_0040 ||
        out_pred !== exp_pred)
      $display("FAIL pd_entry: got v=%b pc=%h ins=%h pred=%b want 1 00001000 08000040 %b",
               out_valid, out_pc, out_instr, out_pred, exp_pred);
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr)
      $display("FAIL pd_next_addr: got req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_addr);
    else n_pass++;
    // Reset with one entry queued and a fetch outstanding.
    out_ready = 1'b0;
    mem_hold  = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RESET_PC)
      $display("FAIL rst_mid: got v=%b req=%b addr=%h want 0 0 %h", out_valid, imem_req,
               imem_addr, RESET_PC);
    else n_pass++;
    mem_auto   = 1'b0;
    gnt        = 1'b0;
    man_rvalid = 1'b1;
    man_rdata  = 32'hDEAD_BEEF;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL rst_stale: got v=%b req=%b addr=%h want 0 1 %h", out_valid, imem_req,
               imem_addr, RESET_PC);
    else n_pass++;
    man_rvalid = 1'b0;
    gnt        = 1'b1;
    next_cycle();
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL rst_outstanding: got %b want 0", imem_req);
    else n_pass++;
    man_rvalid = 1'b1;
    man_rdata  = 32'h1234_5678;
    next_cycle();
    man_rvalid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== 32'h1234_5678)
      $display("FAIL rst_refetch: got v=%b pc=%h ins=%h want 1 %h 12345678", out_valid, out_pc,
               out_instr, RESET_PC);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_predecode_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch stage for the MIPS core: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue for the decode stage. It replaces the single-cycle PC-plus-4 loop with a decoupled, stallable front end that supports redirects (branch/jump resolved downstream) and, optionally, local jump predecode.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of request; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts request this cycle (request fires when imem_req && imem_gnt).
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after the firing grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  downstream redirect (taken branch, jump, jr).
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head (pop when out_valid && out_ready).
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pred  out  1  head was a predecoded J/JAL (0 when macro off).

## Operation
- State: fetch_pc, outstanding flag, drop flag, queue (instr, pc, pred per entry), count 0..DEPTH.
- imem_req = rst_n && !outstanding && (count < DEPTH) && !redirect_valid; imem_addr = fetch_pc.
- Request fire: outstanding ← 1, req_pc latch ← fetch_pc, fetch_pc ← fetch_pc + 4 (wraps modulo 2^32).
- At most one request outstanding; reservation makes a full queue impossible to overflow (request only issued when count < DEPTH and no pop dependency).
- Response (imem_rvalid && outstanding): outstanding ← 0; if drop=1 or redirect_valid this cycle, discard, drop ← 0; else enqueue {imem_rdata, req_pc, pred}.
- Redirect: queue flushed (count ← 0, pointers reset), fetch_pc ← {redirect_pc[31:2],2'b00}; if outstanding and no response this cycle, drop ← 1. Redirect overrides same-cycle pop, enqueue and request.
- imem_rvalid while !outstanding: ignored.
- Simultaneous pop and enqueue with queue full: not possible (enqueue needs reservation); pop and enqueue otherwise both take effect, count unchanged.
- Reset mid-operation: all state cleared asynchronously; a response arriving after rst_n deasserts with no request since reset is ignored.

## Timing
- Reset values: imem_req 0 while rst_n=0, imem_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, out_pred 0; fetch_pc RESET_PC, count 0, outstanding 0, drop 0.
- First request in the first cycle after rst_n rises.
- Enqueue-to-out_valid latency: 1 cycle (registered queue, head visible the cycle after response).
- With zero-wait memory (gnt same cycle, rvalid next cycle): one instruction per 2 cycles; throughput limit is single outstanding request.
- Redirect-to-new-request: request for redirect_pc issued the cycle after redirect if no drop pending; else the cycle after the dropped response.

## Configuration
- FETCH_JUMP_PREDECODE_EN defined: on a non-dropped response with opcode OP_J or OP_JAL, entry enqueued with pred=1 and fetch_pc ← {req_pc_plus4[31:28], instr[25:0], 2'b00} in the same edge (overriding sequential PC, which was already advanced). Downstream redirect still takes priority.
- Undefined: purely sequential fetch; out_pred tied 0; no opcode inspection logic.

## Structure
- mips_pkg: OP_J = 6'h02, OP_JAL = 6'h03, PC_STEP = 32'd4, fetch-entry struct typedef {instr, pc, pred}.
- One sub-module: fetch_fifo (DEPTH-entry synchronous FIFO with flush, count, push/pop, async active-low reset); PC/handshake control stays in fetch_queue.

## Test plan
- Reset release, memory gnt=1, rvalid 1 cycle later, out_ready=1, words 0x20080001… → out_pc 0x0,0x4,0x8 in order, one output per 2 cycles.
- out_ready=0 with DEPTH=4 → exactly 4 entries enqueued, imem_req stays 0; release out_ready → fetch resumes at 0x10.
- Redirect to 0x0000_0102 while request outstanding → in-flight word discarded, next request addr 0x0000_0100, queue empty the following cycle.
- Redirect same cycle as rvalid and out_ready pop → response discarded, out_valid 0 next cycle, fetch_pc 0x100.
- Macro on: word 0x0800_0040 (J) fetched at 0x0000_1000 → out_pred=1, next imem_addr 0x0000_0100; macro off → next imem_addr 0x0000_1004.
- Assert rst_n low with entries queued and request outstanding → out_valid 0 immediately; stale rvalid after release ignored; first request addr RESET_PC.
